// File: rtl/region_dispatcher_if.sv
// region_dispatcher_if: request-in and dispatch-out stream pair for region_dispatcher.
interface region_dispatcher_if #(
   parameter int META_W = 98,
   parameter int RID_W  = 2
);
   logic                    meta_in_tvalid;
   logic                    meta_in_tready;
   logic [META_W-1:0]       meta_in_tdata;
   logic                    meta_out_tvalid;
   logic                    meta_out_tready;
   logic [RID_W+META_W-1:0] meta_out_tdata;
   modport master (
      output meta_in_tvalid, meta_in_tdata, meta_out_tready,
      input  meta_in_tready, meta_out_tvalid, meta_out_tdata
   );
   modport slave (
      input  meta_in_tvalid, meta_in_tdata, meta_out_tready,
      output meta_in_tready, meta_out_tvalid, meta_out_tdata
   );
endinterface

// File: rtl/region_dispatcher.sv
// region_dispatcher: least-loaded PR region dispatch with OID affinity and in-flight accounting.
// Define RR_TIEBREAK_EN to replace the lowest-index tie-break with round-robin.
module region_dispatcher #(
   parameter int META_W    = 98,
   parameter int OID_W     = 16,
   parameter int LOAD_W    = 4,
   parameter int N_REGIONS = 4,
   parameter int QDEPTH    = 16,
   parameter int RID_W     = $clog2(N_REGIONS)
) (
   input  logic                                 aclk,
   input  logic                                 aresetn,
   region_dispatcher_if.slave                   s,
   input  logic [N_REGIONS*(OID_W+LOAD_W)-1:0]  region_stats_in,
   input  logic [N_REGIONS-1:0]                 region_en,
   input  logic [N_REGIONS-1:0]                 region_done,
   output logic [RID_W-1:0]                     lb_ctrl,
   output logic [$clog2(QDEPTH):0]              fifo_count
);
   localparam int SW = OID_W + LOAD_W;
   localparam int PW = $clog2(QDEPTH);
   localparam logic [LOAD_W-1:0] LMAX = '1;
   localparam logic [1:0] IDLE = 2'd0, SELECT = 2'd1, ISSUE = 2'd2;

   logic [META_W-1:0]       mem [QDEPTH];
   logic [PW-1:0]           wp_q, rp_q;
   logic [PW:0]             cnt_q;
   logic                    rdy_q, vld_q;
   logic [SW*N_REGIONS-1:0] stats_q;
   logic [LOAD_W-1:0]       infl_q [N_REGIONS];
   logic [LOAD_W-1:0]       eff [N_REGIONS];
   logic [N_REGIONS-1:0]    cand, aff;
   logic [1:0]              st_q, st_d;
   logic [META_W-1:0]       req_q;
   logic [RID_W-1:0]        rid_q, lb_q, win;
   logic [LOAD_W-1:0]       best;
   logic                    found, best_aff, wr, rd, hs;
   int                      base, idx;

   assign s.meta_in_tready  = rdy_q && cnt_q != (PW+1)'(QDEPTH);
   assign s.meta_out_tvalid = vld_q;
   assign s.meta_out_tdata  = {rid_q, req_q};
   assign lb_ctrl    = lb_q;
   assign fifo_count = cnt_q;
   assign wr = s.meta_in_tvalid && s.meta_in_tready;
   assign hs = vld_q && s.meta_out_tready;
   assign rd = (st_q == IDLE || hs) && cnt_q != '0;
   assign st_d = (st_q == IDLE || hs) ? (rd ? SELECT : IDLE) :
                 st_q == SELECT ? (found ? ISSUE : SELECT) : ISSUE;

   for (genvar r = 0; r < N_REGIONS; r++) begin : g_eff
      logic [LOAD_W:0] sum;
      assign sum     = {1'b0, stats_q[r*SW +: LOAD_W]} + {1'b0, infl_q[r]};
      assign eff[r]  = sum > {1'b0, LMAX} ? LMAX : sum[LOAD_W-1:0];
      assign cand[r] = region_en[r] && eff[r] != LMAX;
      assign aff[r]  = stats_q[r*SW+LOAD_W +: OID_W] == req_q[OID_W-1:0];
   end

`ifdef RR_TIEBREAK_EN
   logic [RID_W-1:0] rr_q;
   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) rr_q <= '0;
      else if (hs) rr_q <= rid_q == RID_W'(N_REGIONS-1) ? '0 : rid_q + 1'b1;
   assign base = int'(rr_q);
`else
   assign base = 0;
`endif

   // Scan in tie-break order; only a strictly better candidate displaces the current one.
   always_comb begin
      found    = 1'b0;
      win      = '0;
      best     = LMAX;
      best_aff = 1'b0;
      idx      = 0;
      for (int k = 0; k < N_REGIONS; k++) begin
         idx = base + k;
         if (idx >= N_REGIONS) idx = idx - N_REGIONS;
         if (cand[idx] && (!found || eff[idx] < best || (eff[idx] == best && aff[idx] && !best_aff))) begin
            found    = 1'b1;
            win      = RID_W'(idx);
            best     = eff[idx];
            best_aff = aff[idx];
         end
      end
   end

   always_ff @(posedge aclk)
      if (wr) mem[wp_q] <= s.meta_in_tdata;

   always_ff @(posedge aclk or negedge aresetn)
      if (!aresetn) begin
         wp_q    <= '0;
         rp_q    <= '0;
         cnt_q   <= '0;
         rdy_q   <= 1'b0;
         vld_q   <= 1'b0;
         stats_q <= '0;
         st_q    <= IDLE;
         req_q   <= '0;
         rid_q   <= '0;
         lb_q    <= '0;
         for (int r = 0; r < N_REGIONS; r++) infl_q[r] <= '0;
      end else begin
         rdy_q   <= 1'b1;
         stats_q <= region_stats_in;
         st_q    <= st_d;
         cnt_q   <= cnt_q + {{PW{1'b0}}, wr} - {{PW{1'b0}}, rd};
         if (wr) wp_q <= wp_q + 1'b1;
         if (rd) begin
            rp_q  <= rp_q + 1'b1;
            req_q <= mem[rp_q];
         end
         if (st_q == SELECT && found) begin
            rid_q <= win;
            vld_q <= 1'b1;
         end
         if (hs) begin
            vld_q <= 1'b0;
            lb_q  <= rid_q;
         end
         // A dispatch and a completion in the same cycle cancel out.
         for (int r = 0; r < N_REGIONS; r++)
            if (hs && rid_q == RID_W'(r) && !region_done[r] && infl_q[r] != LMAX)
               infl_q[r] <= infl_q[r] + 1'b1;
            else if (region_done[r] && !(hs && rid_q == RID_W'(r)) && infl_q[r] != '0)
               infl_q[r] <= infl_q[r] - 1'b1;
      end
endmodule
